// File: rtl/id_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_mp
// Brief    : Multi-port decode-stage integer register file with busy scoreboard.
// Revision : 1.0
// ============================================================================
module id_regfile_mp #(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = $clog2(NUM_REGS),
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int BYPASS       = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_W-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_busy,
    input  logic [NUM_WR_PORTS-1:0]        wr_en,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR_PORTS*DATA_W-1:0] wr_data,
    input  logic                           reserve_en,
    input  logic [ADDR_W-1:0]              reserve_addr,
    input  logic                           flush,
    output logic [NUM_REGS-1:0]            busy_vec,
    output logic [NUM_REGS*DATA_W-1:0]     debug_reg
);

    localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    // Index 0 and indices past the last register are never stored or tracked.
    function automatic logic valid_idx(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < c_NUM_REGS);
    endfunction

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wr_en[w] && valid_idx(wr_addr[w*ADDR_W +: ADDR_W])) begin
                regs_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
                busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // A reservation is applied after the writes so a new producer supersedes the old one.
        if (flush) begin
            busy_d = '0;
        end else if (reserve_en && valid_idx(reserve_addr)) begin
            busy_d[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_dbg
            assign debug_reg[r*DATA_W +: DATA_W] = regs_q[r];
        end

        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

            // Gating on rstn keeps a bypassed write from leaking out during reset.
            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                if (rstn && valid_idx(w_addr)) begin
                    w_data = regs_q[w_addr];
                    w_busy = busy_q[w_addr];
                    if (BYPASS != 0) begin
                        for (int w = 0; w < NUM_WR_PORTS; w++) begin
                            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == w_addr)) begin
                                w_data = wr_data[w*DATA_W +: DATA_W];
                                w_busy = 1'b0;
                            end
                        end
                    end
                end
            end

            assign rd_data[p*DATA_W +: DATA_W] = w_data;
            assign rd_busy[p]                  = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_mp.sv
`default_nettype none
// Bench for id_regfile_mp: two instances (bypassing 32x2W, registered-only 24x1W)
// checked against an array model every cycle plus directed literal checks.
module tb_id_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic          reserve_en;
    logic [AW-1:0] reserve_addr;
    logic          flush;

    logic [2*DW-1:0]  rd_data_a, rd_data_b;
    logic [1:0]       rd_busy_a, rd_busy_b;
    logic [31:0]      busy_vec_a;
    logic [23:0]      busy_vec_b;
    logic [32*DW-1:0] debug_a;
    logic [24*DW-1:0] debug_b;

    always #5 clk = ~clk;

    id_regfile_mp #(
        .DATA_W(DW), .NUM_REGS(32), .ADDR_W(AW),
        .NUM_RD_PORTS(2), .NUM_WR_PORTS(2), .BYPASS(1)
    ) u_dut_a (
        .clk(clk), .rstn(rstn),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .flush(flush),
        .busy_vec(busy_vec_a), .debug_reg(debug_a)
    );

    id_regfile_mp #(
        .DATA_W(DW), .NUM_REGS(24), .ADDR_W(AW),
        .NUM_RD_PORTS(2), .NUM_WR_PORTS(1), .BYPASS(0)
    ) u_dut_b (
        .clk(clk), .rstn(rstn),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]), .wr_data(wr_data[DW-1:0]),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .flush(flush),
        .busy_vec(busy_vec_b), .debug_reg(debug_b)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Architectural model: index 0 = instance a, index 1 = instance b.
    logic [31:0] m_regs [2][32];
    logic [31:0] m_busy [2];

    function automatic int nregs(input int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic int nwr(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) m_regs[d][r] = '0;
            m_busy[d] = '0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge rstn) model_clear();

    always @(posedge clk) begin
        logic [31:0] nb;
        int a;
        if (rstn === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                nb = m_busy[d];
                for (int w = 0; w < nwr(d); w++) begin
                    a = int'(wr_addr[w*AW +: AW]);
                    if (wr_en[w] && a != 0 && a < nregs(d)) begin
                        m_regs[d][a] = wr_data[w*DW +: DW];
                        nb[a] = 1'b0;
                    end
                end
                a = int'(reserve_addr);
                if (flush) nb = '0;
                else if (reserve_en && a != 0 && a < nregs(d)) nb[a] = 1'b1;
                m_busy[d] = nb;
            end
        end
    end

    task automatic exp_rd(input int d, input int a, output logic [31:0] dat, output logic bsy);
        dat = '0;
        bsy = 1'b0;
        if (rstn === 1'b1 && a != 0 && a < nregs(d)) begin
            dat = m_regs[d][a];
            bsy = m_busy[d][a];
            if (d == 0) begin
                for (int w = 0; w < nwr(d); w++) begin
                    if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
                        dat = wr_data[w*DW +: DW];
                        bsy = 1'b0;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        eb;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    exp_rd(d, int'(rd_addr[p*AW +: AW]), ed, eb);
                    chk($sformatf("model rd_data dut%0d p%0d", d, p),
                        (d == 0) ? rd_data_a[p*DW +: DW] : rd_data_b[p*DW +: DW], ed);
                    chk($sformatf("model rd_busy dut%0d p%0d", d, p),
                        {31'd0, (d == 0) ? rd_busy_a[p] : rd_busy_b[p]}, {31'd0, eb});
                end
            end
            chk("model busy_vec dut0", busy_vec_a, m_busy[0]);
            chk("model busy_vec dut1", {8'd0, busy_vec_b}, m_busy[1]);
            for (int r = 0; r < 32; r++)
                chk($sformatf("model debug_reg dut0 r%0d", r), debug_a[r*DW +: DW], m_regs[0][r]);
            for (int r = 0; r < 24; r++)
                chk($sformatf("model debug_reg dut1 r%0d", r), debug_b[r*DW +: DW], m_regs[1][r]);
        end
    end

    task automatic idle();
        wr_en      = '0;
        reserve_en = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [31:0] dat);
        wr_en[w]             = 1'b1;
        wr_addr[w*AW +: AW]  = AW'(a);
        wr_data[w*DW +: DW]  = dat;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        rstn = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; reserve_addr = '0;
        idle();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset busy_vec", busy_vec_a, 32'h0);
        chk("reset rd_data", rd_data_a[31:0], 32'h0);
        #1 rstn = 1'b1;

        next(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 0);
        next(); idle(); set_rd(5, 0); #2;
        chk("x5 read a", rd_data_a[31:0], 32'hDEADBEEF);
        chk("x5 debug a", debug_a[5*DW +: DW], 32'hDEADBEEF);
        chk("x5 read b", rd_data_b[31:0], 32'hDEADBEEF);

        next(); set_wr(0, 0, 32'h1234); set_rd(0, 0); #2;
        chk("x0 read a", rd_data_a[31:0], 32'h0);
        chk("x0 read b", rd_data_b[31:0], 32'h0);

        next(); idle(); set_wr(0, 7, 32'hA5A5A5A5); set_rd(7, 7); #2;
        chk("x0 debug a", debug_a[31:0], 32'h0);
        chk("bypass a p0", rd_data_a[31:0], 32'hA5A5A5A5);
        chk("bypass a p1", rd_data_a[63:32], 32'hA5A5A5A5);
        chk("nobypass b p0", rd_data_b[31:0], 32'h0);
        chk("nobypass b p1", rd_data_b[63:32], 32'h0);

        next(); idle(); #2;
        chk("late b p0", rd_data_b[31:0], 32'hA5A5A5A5);
        chk("late b p1", rd_data_b[63:32], 32'hA5A5A5A5);

        next(); reserve_en = 1'b1; reserve_addr = 5'd3; set_rd(3, 3); #2;
        chk("same-cycle reserve rd_busy a", {30'd0, rd_busy_a}, 32'h0);

        next(); idle(); #2;
        chk("reserved rd_busy a", {30'd0, rd_busy_a}, 32'h3);
        chk("reserved busy_vec a[3]", {31'd0, busy_vec_a[3]}, 32'h1);
        chk("reserved rd_busy b", {30'd0, rd_busy_b}, 32'h3);

        next(); set_wr(0, 3, 32'h42); #2;
        chk("bypass clears rd_busy a", {30'd0, rd_busy_a}, 32'h0);
        chk("bypass x3 a", rd_data_a[31:0], 32'h42);
        chk("no bypass rd_busy b", {30'd0, rd_busy_b}, 32'h3);
        chk("no bypass x3 b", rd_data_b[31:0], 32'h0);

        next(); idle(); #2;
        chk("write cleared busy a", {31'd0, busy_vec_a[3]}, 32'h0);
        chk("write cleared busy b", {31'd0, busy_vec_b[3]}, 32'h0);

        next(); set_wr(0, 3, 32'h55); reserve_en = 1'b1; reserve_addr = 5'd3;
        next(); idle(); #2;
        chk("reserve beats write a", {31'd0, busy_vec_a[3]}, 32'h1);
        chk("reserve+write data a", debug_a[3*DW +: DW], 32'h55);

        next(); set_wr(0, 9, 32'h11); set_wr(1, 9, 32'h22); set_rd(9, 9); #2;
        chk("dual write bypass a", rd_data_a[31:0], 32'h22);
        chk("dual write old b", rd_data_b[31:0], 32'h0);
        next(); idle(); #2;
        chk("dual write winner a", debug_a[9*DW +: DW], 32'h22);
        chk("port0 write b", debug_b[9*DW +: DW], 32'h11);

        next(); reserve_en = 1'b1; reserve_addr = 5'd4;
        next(); reserve_addr = 5'd6;
        next(); reserve_addr = 5'd8; flush = 1'b1; #2;
        chk("pre-flush busy_vec a", busy_vec_a, 32'h58);
        next(); idle(); #2;
        chk("flush busy_vec a", busy_vec_a, 32'h0);
        chk("flush busy_vec b", {8'd0, busy_vec_b}, 32'h0);

        next(); set_wr(0, 25, 32'hFF); reserve_en = 1'b1; reserve_addr = 5'd30; set_rd(25, 30); #2;
        chk("x25 bypass a", rd_data_a[31:0], 32'hFF);
        chk("oob read b", rd_data_b[31:0], 32'h0);
        chk("oob busy b", {30'd0, rd_busy_b}, 32'h0);
        next(); idle(); #2;
        chk("x30 busy_vec a", busy_vec_a, 32'h4000_0000);
        chk("x30 rd_busy a p1", {31'd0, rd_busy_a[1]}, 32'h1);
        chk("x25 debug a", debug_a[25*DW +: DW], 32'hFF);
        chk("oob busy_vec b", {8'd0, busy_vec_b}, 32'h0);

        next(); set_wr(0, 12, 32'hCAFE0001); set_wr(1, 13, 32'hCAFE0002); set_rd(12, 13);
        next(); idle(); set_wr(0, 14, 32'h77); set_rd(14, 12);
        #1 rstn = 1'b0;
        #1;
        chk("async rst rd_data p0 a", rd_data_a[31:0], 32'h0);
        chk("async rst rd_data p1 a", rd_data_a[63:32], 32'h0);
        chk("async rst rd_busy a", {30'd0, rd_busy_a}, 32'h0);
        chk("async rst busy_vec a", busy_vec_a, 32'h0);
        chk("async rst debug x12 a", debug_a[12*DW +: DW], 32'h0);
        chk("async rst debug x12 b", debug_b[12*DW +: DW], 32'h0);
        next(); idle(); rstn = 1'b1;
        next(); #2;
        chk("dropped write x14 a", rd_data_a[31:0], 32'h0);

        next(); set_wr(0, 1, 32'h0000_0101); set_wr(1, 2, 32'h0000_0202); set_rd(1, 2);
        next(); idle(); set_wr(0, 2, 32'h0000_0303); reserve_en = 1'b1; reserve_addr = 5'd1;
        next(); idle(); set_rd(2, 1);
        next(); next();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
